// File: rtl/ps2_rx_arbiter_pkg.sv
// Shared definitions for the PS/2 receive arbiter: source tags, default FIFO depth,
// output-stage state encoding and the round-robin pick.
package ps2_rx_arbiter_pkg;

    localparam logic SRC_MOUSE     = 1'b0;
    localparam logic SRC_KBD       = 1'b1;
    localparam int   DEFAULT_DEPTH = 4;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // With both heads available the channel not granted last wins; otherwise the only one present.
    function automatic logic rr_pick(input logic [1:0] nonempty, input logic last_grant);
        logic pick;
        if (&nonempty) begin
            pick = ~last_grant;
        end else if (nonempty[SRC_KBD]) begin
            pick = SRC_KBD;
        end else begin
            pick = SRC_MOUSE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// 8-bit synchronous show-ahead FIFO: dout always presents the head entry while not empty.
module ps2_byte_fifo
    import ps2_rx_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [7:0]    din,
    input  logic          rd,
    output logic [7:0]    dout,
    output logic [AW:0]   cnt,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          w_do_wr;
    logic          w_do_rd;

    assign full    = (r_cnt == FULL_CNT);
    assign empty   = (r_cnt == '0);
    assign cnt     = r_cnt;
    assign dout    = r_mem[r_rd_ptr];
    assign w_do_wr = wr & ~full;
    assign w_do_rd = rd & ~empty;

    // Storage is left unreset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_arbiter.sv
// Merges the mouse and keyboard PS/2 receive streams onto one registered valid/ready
// byte port, with per-channel buffering, round-robin selection and overflow flags.
module ps2_rx_arbiter
    import ps2_rx_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rda,
    input  logic [7:0] rx_data0,
    input  logic [7:0] rx_data1,
    input  logic [1:0] sw_en,
    output logic [1:0] rx_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_src,
    output logic [1:0] ovf,
    input  logic [1:0] ovf_clr
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]  w_din  [2];
    logic [7:0]  w_head [2];
    logic [AW:0] w_cnt  [2];
    logic [1:0]  w_full;
    logic [1:0]  w_empty;
    logic [1:0]  w_pop;
    logic        w_load;
    logic        w_any;
    logic        w_grant;

    out_state_e  r_state;
    logic        r_last_grant;
    logic [7:0]  r_out_data;
    logic        r_out_src;

    assign w_din[0] = rx_data0;
    assign w_din[1] = rx_data1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic r_rx_en;
            logic r_ovf;

            ps2_byte_fifo #(
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .wr    (rda[gi]),
                .din   (w_din[gi]),
                .rd    (w_pop[gi]),
                .dout  (w_head[gi]),
                .cnt   (w_cnt[gi]),
                .full  (w_full[gi]),
                .empty (w_empty[gi])
            );

            assign w_pop[gi] = w_load & w_any & (w_grant == 1'(gi));

            // Fullness is judged on the registered count, so a same-cycle pop never makes room.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rx_en <= 1'b0;
                    r_ovf   <= 1'b0;
                end else begin
                    r_rx_en <= sw_en[gi] & (w_cnt[gi] < FULL_CNT);
                    if (rda[gi] & w_full[gi]) begin
                        r_ovf <= 1'b1;
                    end else if (ovf_clr[gi]) begin
                        r_ovf <= 1'b0;
                    end
                end
            end

            assign rx_en[gi] = r_rx_en;
            assign ovf[gi]   = r_ovf;
        end
    endgenerate

    assign w_any   = ~&w_empty;
    assign w_grant = rr_pick(~w_empty, r_last_grant);
    assign w_load  = (r_state == OUT_EMPTY) | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= OUT_EMPTY;
            r_last_grant <= SRC_MOUSE;
            r_out_data   <= 8'h00;
            r_out_src    <= SRC_MOUSE;
        end else begin
            case (r_state)
                OUT_EMPTY: begin
                    if (w_any) begin
                        r_state      <= OUT_FULL;
                        r_out_data   <= w_head[w_grant];
                        r_out_src    <= w_grant;
                        r_last_grant <= w_grant;
                    end
                end
                OUT_FULL: begin
                    if (out_ready) begin
                        if (w_any) begin
                            r_out_data   <= w_head[w_grant];
                            r_out_src    <= w_grant;
                            r_last_grant <= w_grant;
                        end else begin
                            r_state <= OUT_EMPTY;
                        end
                    end
                end
                default: r_state <= OUT_EMPTY;
            endcase
        end
    end

    assign out_valid = (r_state == OUT_FULL);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_ps2_rx_arbiter.sv
// Directed self-checking bench for ps2_rx_arbiter with DEPTH=4.
module tb_ps2_rx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rda;
    logic [7:0] rx_data0;
    logic [7:0] rx_data1;
    logic [1:0] sw_en;
    logic [1:0] rx_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_src;
    logic [1:0] ovf;
    logic [1:0] ovf_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps2_rx_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rda       (rda),
        .rx_data0  (rx_data0),
        .rx_data1  (rx_data1),
        .sw_en     (sw_en),
        .rx_en     (rx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rda = '0; rx_data0 = '0; rx_data1 = '0;
        sw_en = '0; out_ready = 1'b0; ovf_clr = '0;
        repeat (3) step();
        checks++;
        if ({rx_en, out_valid, out_data, out_src, ovf} !== 14'h0) begin
            failures++;
            $display("FAIL reset_values got rx_en=%b valid=%b data=%h src=%b ovf=%b exp all zero",
                     rx_en, out_valid, out_data, out_src, ovf);
        end
        sw_en = 2'b11; out_ready = 1'b1; rst_n = 1'b1;
        step();
        checks++;
        if (rx_en !== 2'b11) begin
            failures++;
            $display("FAIL reset_rx_en_up got=%b exp=11", rx_en);
        end
    endtask

    task automatic test_tie;
        logic [7:0] exp_d [6];
        logic       exp_s [6];
        exp_d = '{8'h1C, 8'h08, 8'h1D, 8'h09, 8'h1E, 8'h0A};
        exp_s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c < 3) begin
                rda = 2'b11; rx_data0 = 8'h08 + 8'(c); rx_data1 = 8'h1C + 8'(c);
            end else begin
                rda = 2'b00;
            end
            if (c >= 2 && c < 8) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_d[c-2] || out_src !== exp_s[c-2]) begin
                    failures++;
                    $display("FAIL tie[%0d] got v=%b d=%h s=%b exp v=1 d=%h s=%b",
                             c - 2, out_valid, out_data, out_src, exp_d[c-2], exp_s[c-2]);
                end else begin
                    $display("tie txn byte=%h src=%0d", out_data, out_src);
                end
            end else if (c == 8) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL tie_drained got valid=%b exp=0", out_valid);
                end
            end
            step();
        end
    endtask

    task automatic test_single;
        rda = 2'b10; rx_data1 = 8'h1C;
        step();
        rda = 2'b00;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early got valid=%b exp=0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h1C || out_src !== 1'b1) begin
            failures++;
            $display("FAIL single_out got v=%b d=%h s=%b exp v=1 d=1c s=1", out_valid, out_data, out_src);
        end else begin
            $display("single txn byte=%h src=%0d", out_data, out_src);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_once got valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            rda = 2'b10; rx_data1 = 8'(k);
            step();
        end
        rda = 2'b00;
        checks++;
        if (rx_en !== 2'b11) begin
            failures++;
            $display("FAIL bp_rx_en_lag got=%b exp=11", rx_en);
        end
        step();
        checks++;
        if (rx_en !== 2'b01 || out_valid !== 1'b1 || out_data !== 8'h01) begin
            failures++;
            $display("FAIL bp_full got rx_en=%b v=%b d=%h exp rx_en=01 v=1 d=01", rx_en, out_valid, out_data);
        end
        rda = 2'b10; rx_data1 = 8'h06;
        step();
        rda = 2'b00;
        checks++;
        if (ovf !== 2'b10) begin
            failures++;
            $display("FAIL bp_ovf got=%b exp=10", ovf);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(k) || out_src !== 1'b1) begin
                failures++;
                $display("FAIL bp_drain[%0d] got v=%b d=%h s=%b exp v=1 d=%h s=1",
                         k, out_valid, out_data, out_src, 8'(k));
            end else begin
                $display("bp txn byte=%h src=%0d", out_data, out_src);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || rx_en !== 2'b11) begin
            failures++;
            $display("FAIL bp_end got v=%b rx_en=%b exp v=0 rx_en=11", out_valid, rx_en);
        end
        ovf_clr = 2'b10;
        step();
        ovf_clr = 2'b00;
        checks++;
        if (ovf !== 2'b00) begin
            failures++;
            $display("FAIL bp_ovf_clr got=%b exp=00", ovf);
        end
    endtask

    task automatic test_enable;
        out_ready = 1'b0;
        rda = 2'b10; rx_data1 = 8'hAA;
        step();
        rx_data1 = 8'hBB;
        step();
        rda = 2'b00; sw_en = 2'b01;
        step();
        checks++;
        if (rx_en !== 2'b01 || out_valid !== 1'b1 || out_data !== 8'hAA) begin
            failures++;
            $display("FAIL en_off got rx_en=%b v=%b d=%h exp rx_en=01 v=1 d=aa", rx_en, out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hBB || out_src !== 1'b1) begin
            failures++;
            $display("FAIL en_drain got v=%b d=%h s=%b exp v=1 d=bb s=1", out_valid, out_data, out_src);
        end else begin
            $display("en txn byte=%h src=%0d", out_data, out_src);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL en_empty got valid=%b exp=0", out_valid);
        end
        sw_en = 2'b11;
        step();
    endtask

    task automatic test_ovf_clear;
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            rda = 2'b01; rx_data0 = 8'h40 + 8'(k);
            step();
        end
        rda = 2'b00;
        checks++;
        if (ovf !== 2'b01 || out_data !== 8'h41 || out_src !== 1'b0) begin
            failures++;
            $display("FAIL ovf_set got ovf=%b d=%h s=%b exp ovf=01 d=41 s=0", ovf, out_data, out_src);
        end
        ovf_clr = 2'b01;
        step();
        ovf_clr = 2'b00;
        checks++;
        if (ovf !== 2'b00) begin
            failures++;
            $display("FAIL ovf_clr_alone got=%b exp=00", ovf);
        end
        rda = 2'b01; rx_data0 = 8'h99; ovf_clr = 2'b01;
        step();
        rda = 2'b00; ovf_clr = 2'b00;
        checks++;
        if (ovf !== 2'b01) begin
            failures++;
            $display("FAIL ovf_set_wins got=%b exp=01", ovf);
        end
    endtask

    task automatic test_reset_mid;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || rx_en !== 2'b00 || ovf !== 2'b00 || out_data !== 8'h00) begin
            failures++;
            $display("FAIL async_reset got v=%b rx_en=%b ovf=%b d=%h exp all zero",
                     out_valid, rx_en, ovf, out_data);
        end
        repeat (2) step();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL stale_byte[%0d] got v=%b d=%h exp v=0", c, out_valid, out_data);
            end
        end
        checks++;
        if (rx_en !== 2'b11) begin
            failures++;
            $display("FAIL post_reset_rx_en got=%b exp=11", rx_en);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_backpressure();
        test_enable();
        test_ovf_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
